uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo_pkg.sv | 21 ++
 rtl/uart_rx_fifo_mem.sv | 22 ++
 rtl/uart_rx_fifo.sv | 112 +++++++++++
 tb/tb_uart_rx_fifo.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART receive FIFO: default sizes and entry field layout.
// Entry layout is {frame_error, parity_error, data}.
package uart_rx_fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_DEPTH      = 16;
  localparam int unsigned DEF_ENTRY_W    = DEF_DATA_WIDTH + 2;

  function automatic int unsigned entry_w(input int unsigned dw);
    return dw + 2;
  endfunction

  function automatic int unsigned parity_pos(input int unsigned dw);
    return dw;
  endfunction

  function automatic int unsigned frame_pos(input int unsigned dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Entry storage for the UART receive FIFO: registered write, asynchronous read, no reset.
module uart_rx_fifo_mem #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: edge-detected push from the receiver, first-word-fall-through read.
// Optional macro UART_RX_FIFO_ERR_DROP_EN discards errored characters and counts them.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx_data_valid,
  input  logic [DATA_WIDTH-1:0]      rx_parallel_data,
  input  logic                       rx_parity_error,
  input  logic                       rx_frame_error,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_parity_error,
  output logic                       rd_frame_error,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  input  logic                       overflow_clear,
  output logic [7:0]                 err_drop_count
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned ENTRY_W = entry_w(DATA_WIDTH);
  localparam int unsigned PAR_BIT = parity_pos(DATA_WIDTH);
  localparam int unsigned FRM_BIT = frame_pos(DATA_WIDTH);

  logic [AW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic               valid_q;
  logic               overflow_q, overflow_d;
  logic               push_stb, store_req, do_push, do_pop;
  logic [ENTRY_W-1:0] head;

  assign push_stb = rx_data_valid & ~valid_q;

`ifdef UART_RX_FIFO_ERR_DROP_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       drop_err;

  assign drop_err  = push_stb & (rx_parity_error | rx_frame_error);
  assign store_req = push_stb & ~drop_err;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (drop_err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_drop_count = err_cnt_q;
`else
  assign store_req      = push_stb;
  assign err_drop_count = '0;
`endif

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count = wr_ptr_q - rd_ptr_q;

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = rd_en & ~empty;
  assign do_push = store_req & (~full | do_pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (overflow_clear) overflow_d = 1'b0;
    if (store_req && full && !do_pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      valid_q    <= rx_data_valid;
      overflow_q <= overflow_d;
    end
  end

  uart_rx_fifo_mem #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (do_push & ~reset),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i ({rx_frame_error, rx_parity_error, rx_parallel_data}),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (head)
  );

  assign rd_data         = head[DATA_WIDTH-1:0];
  assign rd_parity_error = head[PAR_BIT];
  assign rd_frame_error  = head[FRM_BIT];
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DATA_WIDTH=8, DEPTH=16).
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset, rx_data_valid, rx_parity_error, rx_frame_error, rd_en, overflow_clear;
  logic [7:0] rx_parallel_data, rd_data, err_drop_count;
  logic       rd_parity_error, rd_frame_error, empty, full, overflow;
  logic [4:0] count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .rx_data_valid    (rx_data_valid),
    .rx_parallel_data (rx_parallel_data),
    .rx_parity_error  (rx_parity_error),
    .rx_frame_error   (rx_frame_error),
    .rd_en            (rd_en),
    .rd_data          (rd_data),
    .rd_parity_error  (rd_parity_error),
    .rd_frame_error   (rd_frame_error),
    .empty            (empty),
    .full             (full),
    .count            (count),
    .overflow         (overflow),
    .overflow_clear   (overflow_clear),
    .err_drop_count   (err_drop_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle valid pulse followed by a low cycle so the next pulse is a fresh edge.
  task automatic push(input logic [7:0] d, input logic pe, input logic fe);
    rx_data_valid = 1'b1; rx_parallel_data = d; rx_parity_error = pe; rx_frame_error = fe;
    tick();
    rx_data_valid = 1'b0; rx_parity_error = 1'b0; rx_frame_error = 1'b0;
    tick();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rx_data_valid = 1'b0; rx_parallel_data = '0; rx_parity_error = 1'b0;
    rx_frame_error = 1'b0; rd_en = 1'b0; overflow_clear = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_count", 32'(count), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_errcnt", 32'(err_drop_count), 0);

    // Two pushes, two pops with one-cycle push latency.
    rx_data_valid = 1'b1; rx_parallel_data = 8'hA5;
    tick();
    check("p1_count", 32'(count), 1);
    check("p1_head", 32'(rd_data), 32'hA5);
    rx_data_valid = 1'b0; tick();
    push(8'h3C, 1'b0, 1'b0);
    check("p2_count", 32'(count), 2);
    check("pop1_head", 32'(rd_data), 32'hA5);
    pop();
    check("pop1_count", 32'(count), 1);
    check("pop2_head", 32'(rd_data), 32'h3C);
    pop();
    check("pop2_count", 32'(count), 0);
    check("pop2_empty", 32'(empty), 1);

    // Level held high for 10 cycles gives exactly one entry.
    rx_data_valid = 1'b1; rx_parallel_data = 8'h55;
    repeat (10) tick();
    rx_data_valid = 1'b0; tick();
    check("lvl_count", 32'(count), 1);
    check("lvl_head", 32'(rd_data), 32'h55);
    pop();
    pop();
    check("emptypop_count", 32'(count), 0);
    check("emptypop_empty", 32'(empty), 1);

    // Fill past capacity; 0x20 must be dropped.
    for (int i = 0; i < 17; i++) push(8'(8'h10 + i), 1'b0, 1'b0);
    check("fill_full", 32'(full), 1);
    check("fill_count", 32'(count), 16);
    check("fill_ovf", 32'(overflow), 1);
    check("fill_head", 32'(rd_data), 32'h10);
    overflow_clear = 1'b1; tick(); overflow_clear = 1'b0;
    check("ovf_clear", 32'(overflow), 0);

    // Push and pop together while full.
    rx_data_valid = 1'b1; rx_parallel_data = 8'h99; rd_en = 1'b1;
    tick();
    rx_data_valid = 1'b0; rd_en = 1'b0;
    check("fullpp_count", 32'(count), 16);
    check("fullpp_full", 32'(full), 1);
    check("fullpp_ovf", 32'(overflow), 0);
    tick();
    for (int i = 0; i < 15; i++) begin
      check($sformatf("drain_%0d", i), 32'(rd_data), 32'(8'h11 + i));
      pop();
    end
    check("drain_last", 32'(rd_data), 32'h99);
    pop();
    check("drain_empty", 32'(empty), 1);
    check("drain_count", 32'(count), 0);

    // Refill across pointer wrap; set beats clear in the same cycle.
    for (int i = 0; i < 16; i++) push(8'(8'h40 + i), 1'b0, 1'b0);
    check("wrap_full", 32'(full), 1);
    check("wrap_head", 32'(rd_data), 32'h40);
    rx_data_valid = 1'b1; rx_parallel_data = 8'hEE; overflow_clear = 1'b1;
    tick();
    rx_data_valid = 1'b0; overflow_clear = 1'b0;
    check("setwins_ovf", 32'(overflow), 1);
    check("setwins_count", 32'(count), 16);
    tick();

    // Reset mid-operation overrides a concurrent push.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 3; i++) push(8'(8'h60 + i), 1'b0, 1'b0);
    check("pre_rst_count", 32'(count), 3);
    reset = 1'b1; rx_data_valid = 1'b1; rx_parallel_data = 8'h6F;
    tick();
    reset = 1'b0; rx_data_valid = 1'b0;
    check("midrst_empty", 32'(empty), 1);
    check("midrst_count", 32'(count), 0);
    check("midrst_ovf", 32'(overflow), 0);
    tick();
    check("midrst_nopush", 32'(count), 0);

    // Push and pop together while empty: push lands, pop ignored.
    rx_data_valid = 1'b1; rx_parallel_data = 8'h77; rd_en = 1'b1;
    tick();
    rx_data_valid = 1'b0; rd_en = 1'b0;
    check("emptypp_count", 32'(count), 1);
    check("emptypp_head", 32'(rd_data), 32'h77);
    tick();
    pop();

    // Errored characters.
    push(8'h12, 1'b1, 1'b0);
`ifdef UART_RX_FIFO_ERR_DROP_EN
    check("perr_empty", 32'(empty), 1);
    check("perr_errcnt", 32'(err_drop_count), 1);
    push(8'h34, 1'b0, 1'b1);
    check("ferr_errcnt", 32'(err_drop_count), 2);
    check("ferr_ovf", 32'(overflow), 0);
`else
    check("perr_count", 32'(count), 1);
    check("perr_data", 32'(rd_data), 32'h12);
    check("perr_pflag", 32'(rd_parity_error), 1);
    check("perr_fflag", 32'(rd_frame_error), 0);
    pop();
    push(8'h34, 1'b0, 1'b1);
    check("ferr_data", 32'(rd_data), 32'h34);
    check("ferr_pflag", 32'(rd_parity_error), 0);
    check("ferr_fflag", 32'(rd_frame_error), 1);
    check("ferr_errcnt", 32'(err_drop_count), 0);
`endif

    // Valid held high across reset release pushes once.
    rx_data_valid = 1'b1; rx_parallel_data = 8'hC3; reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("relpush_count", 32'(count), 1);
    check("relpush_head", 32'(rd_data), 32'hC3);
    repeat (3) tick();
    check("relpush_once", 32'(count), 1);
    rx_data_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
